// File: rtl/bus_access_sched_if.sv
// Bus access scheduler interface: master requests, slave ack, grant and
// completion signals, plus a debug view of the scheduler state.
//
// Handshake: a master raises mX_req_i and holds it until it sees its one-cycle
// mX_ack_o pulse; dropping it earlier does not cancel an issued transaction.
// The scheduler starts a slave transaction with a one-cycle s_req_o strobe and
// treats the first s_ack_i seen in that transaction as completion; s_ack_i
// outside a transaction is ignored.
interface bus_access_sched_if;
  logic       m0_req_i;
  logic       m1_req_i;
  logic       m2_req_i;
  logic       s_ack_i;
  logic [1:0] grant_o;
  logic       grant_vld_o;
  logic       s_req_o;
  logic       m0_ack_o;
  logic       m1_ack_o;
  logic       m2_ack_o;
  logic       hold_flag_o;
  logic       err_o;
  logic [1:0] state_o;

  modport slave (
    input  m0_req_i, m1_req_i, m2_req_i, s_ack_i,
    output grant_o, grant_vld_o, s_req_o, m0_ack_o, m1_ack_o, m2_ack_o,
           hold_flag_o, err_o, state_o
  );

  modport master (
    output m0_req_i, m1_req_i, m2_req_i, s_ack_i,
    input  grant_o, grant_vld_o, s_req_o, m0_ack_o, m1_ack_o, m2_ack_o,
           hold_flag_o, err_o, state_o
  );
endinterface

// File: rtl/bus_access_sched.sv
// Sequential access scheduler for the shared system bus (ex=m0, if=m1, jtag=m2).
// One transaction at a time: arbitrate in IDLE, hold the grant through ACCESS
// until the slave acks, pulse the owner's ack in DONE, then return to IDLE.
// m1 is protected from starvation by m2 through a saturating counter.
// Optional slave-timeout watchdog: define BUS_ACCESS_SCHED_TIMEOUT_EN.
module bus_access_sched #(
  parameter int STARVE_MAX     = 4
`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
  , parameter int TO_W           = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  bus_access_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       vld_q, vld_d;
  logic       sreq_q, sreq_d;
  logic [2:0] ack_q, ack_d;
  logic       hold_q, hold_d;
  logic [3:0] starve_q, starve_d;
  logic       to_hit;

`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  assign to_hit = (to_q == TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  // One-hot completion pulse for the current bus owner.
  function automatic logic [2:0] owner_ack(input logic [1:0] g);
    logic [2:0] a;
    a = 3'b000;
    case (g)
      2'd0:    a = 3'b001;
      2'd1:    a = 3'b010;
      2'd2:    a = 3'b100;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    vld_d    = vld_q;
    sreq_d   = 1'b0;
    ack_d    = 3'b000;
    hold_d   = hold_q;
    starve_d = starve_q;
`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
    to_d     = to_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i || bus.m2_req_i) begin
          state_d = ACCESS;
          vld_d   = 1'b1;
          sreq_d  = 1'b1;
`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
          if (bus.m0_req_i) begin
            grant_d = 2'd0;
            hold_d  = 1'b1;
          end else if (bus.m1_req_i && (starve_q == STARVE_LIM)) begin
            // m1 has waited behind m2 long enough: force it in.
            grant_d  = 2'd1;
            hold_d   = 1'b0;
            starve_d = '0;
          end else if (bus.m2_req_i) begin
            grant_d = 2'd2;
            hold_d  = 1'b1;
            if (bus.m1_req_i && (starve_q < STARVE_LIM)) starve_d = starve_q + 4'd1;
          end else begin
            grant_d  = 2'd1;
            hold_d   = 1'b0;
            starve_d = '0;
          end
        end
      end
      ACCESS: begin
        if (bus.s_ack_i) begin
          state_d = DONE;
          ack_d   = owner_ack(grant_q);
        end else if (to_hit) begin
          // Slave never answered: complete the transaction with an error.
          state_d = DONE;
          ack_d   = owner_ack(grant_q);
`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
          err_d   = 1'b1;
        end else begin
          to_d    = to_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        hold_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        hold_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= 2'd1;
      vld_q    <= 1'b0;
      sreq_q   <= 1'b0;
      ack_q    <= 3'b000;
      hold_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      vld_q    <= vld_d;
      sreq_q   <= sreq_d;
      ack_q    <= ack_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end

`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
  // Watchdog counter and error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.grant_o     = grant_q;
  assign bus.grant_vld_o = vld_q;
  assign bus.s_req_o     = sreq_q;
  assign bus.m0_ack_o    = ack_q[0];
  assign bus.m1_ack_o    = ack_q[1];
  assign bus.m2_ack_o    = ack_q[2];
  assign bus.hold_flag_o = hold_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_bus_access_sched.sv
// Testbench for bus_access_sched: directed scenarios followed by randomized
// request/latency traffic, checked against a transaction-level model of the
// arbitration rules (priority, m1 anti-starvation, fixed turnaround).
module tb_bus_access_sched;

  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_access_sched_if bus ();

`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
  bus_access_sched #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYCLES(16), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`else
  bus_access_sched #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_pass   = 0;
  int n_checks = 0;
  logic [2:0] pend = 3'b000;   // requests currently held by the masters
  int starve_m = 0;            // model: consecutive m2 wins while m1 waits

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: who wins given the held requests and the current starvation count.
  function automatic int pick(input logic [2:0] p);
    if (p[0]) return 0;
    if (p[1] && starve_m == STARVE_MAX) return 1;
    if (p[2]) return 2;
    if (p[1]) return 1;
    return -1;
  endfunction

  task automatic commit(input int w, input logic [2:0] p);
    if (w == 2 && p[1]) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    if (w == 1) starve_m = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pend(input logic [2:0] p);
    pend = p;
    bus.m0_req_i = p[0];
    bus.m1_req_i = p[1];
    bus.m2_req_i = p[2];
  endtask

  function automatic logic [2:0] acks();
    return {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
  endfunction

  // One transaction, starting in an IDLE cycle with pend non-empty. The slave
  // acks in ACCESS cycle k; the owner drops its request in ACCESS cycle drop_at
  // (or at its ack if drop_at < 0). Returns in the following IDLE cycle.
  task automatic run_txn(input int k, input int drop_at, output int g_obs);
    int w;
    logic h;
    set_pend(pend);
    bus.s_ack_i = 1'b0;
    w = pick(pend);
    commit(w, pend);
    h = (w != 1);
    step;
    g_obs = int'(bus.grant_o);
    for (int i = 0; i <= k; i++) begin
      check("acc_sreq",  bus.s_req_o, (i == 0));
      check("acc_grant", bus.grant_o, w);
      check("acc_vld",   bus.grant_vld_o, 1);
      check("acc_hold",  bus.hold_flag_o, h);
      check("acc_ack",   acks(), 0);
      check("acc_state", bus.state_o, 2'b01);
      if (i == drop_at) begin
        pend[w] = 1'b0;
        set_pend(pend);
      end
      bus.s_ack_i = (i == k);
      step;
    end
    bus.s_ack_i = 1'b0;
    check("done_ack",  acks(), 32'd1 << w);
    check("done_vld",  bus.grant_vld_o, 1);
    check("done_hold", bus.hold_flag_o, h);
    check("done_err",  bus.err_o, 0);
    check("done_sreq", bus.s_req_o, 0);
    pend[w] = 1'b0;
    set_pend(pend);
    step;
    check("idle_vld",   bus.grant_vld_o, 0);
    check("idle_hold",  bus.hold_flag_o, 0);
    check("idle_ack",   acks(), 0);
    check("idle_grant", bus.grant_o, w);
    check("idle_sreq",  bus.s_req_o, 0);
  endtask

  // ---------------- stimulus ----------------
  int g;
  int n;
  int exp_seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  initial begin
    set_pend(3'b000);
    bus.s_ack_i = 1'b0;
    rst = 1'b0;
    step;
    step;
    check("rst_grant", bus.grant_o, 1);
    check("rst_vld",   bus.grant_vld_o, 0);
    check("rst_sreq",  bus.s_req_o, 0);
    check("rst_ack",   acks(), 0);
    check("rst_hold",  bus.hold_flag_o, 0);
    check("rst_err",   bus.err_o, 0);
    check("rst_state", bus.state_o, 2'b00);
    rst = 1'b1;
    step;

    // All three request together; slave acks one cycle after the strobe.
    set_pend(3'b111);
    run_txn(1, -1, g);
    check("t1_grant", g, 0);
    set_pend(3'b000);
    step;

    // m1 alone, slave acks in the strobe cycle.
    set_pend(3'b010);
    run_txn(0, -1, g);
    check("t3_grant", g, 1);

    // m1 and m2 requesting continuously: m1 forced in every fifth grant.
    for (int t = 0; t < 10; t++) begin
      set_pend(3'b110);
      run_txn(0, -1, g);
      check("t2_seq", g, exp_seq[t]);
    end
    set_pend(3'b000);
    step;

    // m0 drops its request right after the strobe; ack still arrives once.
    set_pend(3'b001);
    run_txn(4, 1, g);
    for (int i = 0; i < 3; i++) begin
      check("t6_no_sreq", bus.s_req_o, 0);
      check("t6_idle",    bus.grant_vld_o, 0);
      step;
    end

    // Reset during an m0 access.
    set_pend(3'b001);
    step;
    check("t5_sreq", bus.s_req_o, 1);
    step;
    rst = 1'b0;
    #1;
    check("t5_vld",   bus.grant_vld_o, 0);
    check("t5_hold",  bus.hold_flag_o, 0);
    check("t5_grant", bus.grant_o, 1);
    check("t5_ack",   acks(), 0);
    check("t5_err",   bus.err_o, 0);
    step;
    rst = 1'b1;
    starve_m = 0;
    run_txn(1, -1, g);
    check("t5_fresh", g, 0);

    // Slave never answers an m2 access.
`ifdef BUS_ACCESS_SCHED_TIMEOUT_EN
    set_pend(3'b100);
    commit(pick(pend), pend);
    step;
    check("t4_sreq", bus.s_req_o, 1);
    n = 0;
    while (acks() == 3'b000 && n < 40) begin
      step;
      n++;
    end
    check("t4_latency", n, 17);
    check("t4_ack", acks(), 3'b100);
    check("t4_err", bus.err_o, 1);
    set_pend(3'b000);
    step;
    check("t4_idle", bus.grant_vld_o, 0);
    check("t4_err_clr", bus.err_o, 0);
`else
    set_pend(3'b100);
    run_txn(99, -1, g);
    check("t4_grant", g, 2);
`endif

    // Random traffic: new requests join between transactions, random latency.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] p;
      p = pend | 3'($urandom_range(0, 7));
      if (p == 3'b000) p = 3'b001 << $urandom_range(0, 2);
      set_pend(p);
      run_txn($urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? 0 : -1, g);
    end

    set_pend(3'b000);
    step;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
